// File: rtl/morse_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | morse_pkg : shared state encoding and unit thresholds            |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  localparam logic [2:0] DASH_UNITS     = 3'd2;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd2;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd5;
  localparam logic [2:0] MARK_ERR_UNITS = 3'd5;
  localparam logic [2:0] MAX_ELEMS      = 3'd6;

  // Element value appended for a mark that lasted the given whole units.
  function automatic logic is_dash(input logic [2:0] units);
    return (units >= DASH_UNITS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pin_debounce : two-flop synchroniser plus hold-time debouncer    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16384
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic PIN_IN,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  // Any cycle where the synchronised input agrees with the accepted level restarts the hold count.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], PIN_IN};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync[1];
          r_rise  <= r_sync[1];
          r_fall  <= ~r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign LEVEL = r_level;
  assign RISE  = r_rise;
  assign FALL  = r_fall;

endmodule
`default_nettype wire

// File: rtl/morse_rx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | morse_rx : decodes a debounced Morse line into character codes   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module morse_rx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 2097152,
  parameter int DEBOUNCE_CYCLES = 16384
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       PIN_IN,
  output logic       SYM_VALID,
  output logic [5:0] SYM_CODE,
  output logic [2:0] SYM_LEN,
  output logic       WORD_GAP,
  output logic       ERR
);

  localparam int PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_wrap;

  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_units;

  state_t           r_state;
  logic [5:0]       r_code;
  logic [2:0]       r_len;
  logic             r_mark_err;
  logic             r_sym_seen;
  logic             r_sym_valid;
  logic [5:0]       r_sym_code;
  logic [2:0]       r_sym_len;
  logic             r_word_gap;
  logic             r_err;

  pin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK   (CLK),
    .RESETN(RESETN),
    .PIN_IN(PIN_IN),
    .LEVEL (w_level),
    .RISE  (w_rise),
    .FALL  (w_fall)
  );

  assign w_edge = w_rise | w_fall;
  assign w_wrap = (r_pre == PRE_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_pre   <= '0;
      r_units <= 3'd0;
    end else if (w_edge) begin
      r_pre   <= '0;
      r_units <= 3'd0;
    end else if (w_wrap) begin
      r_pre <= '0;
      if (r_units != 3'd7) begin
        r_units <= r_units + 3'd1;
      end
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Threshold tests fire on the wrap that moves r_units onto the threshold value.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state     <= ST_IDLE;
      r_code      <= 6'd0;
      r_len       <= 3'd0;
      r_mark_err  <= 1'b0;
      r_sym_seen  <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_code  <= 6'd0;
      r_sym_len   <= 3'd0;
      r_word_gap  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      r_word_gap  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state    <= ST_MARK;
            r_code     <= 6'd0;
            r_len      <= 3'd0;
            r_mark_err <= 1'b0;
          end
        end
        ST_MARK: begin
          if (r_mark_err) begin
            if (!w_level) begin
              r_state    <= ST_IDLE;
              r_mark_err <= 1'b0;
            end
          end else if (w_fall) begin
            if (r_len == MAX_ELEMS) begin
              r_err   <= 1'b1;
              r_code  <= 6'd0;
              r_len   <= 3'd0;
              r_state <= ST_IDLE;
            end else begin
              r_code[r_len] <= is_dash(r_units);
              r_len         <= r_len + 3'd1;
              r_state       <= ST_SPACE;
            end
          end else if (w_wrap && (r_units == MARK_ERR_UNITS - 3'd1)) begin
            r_err      <= 1'b1;
            r_mark_err <= 1'b1;
            r_code     <= 6'd0;
            r_len      <= 3'd0;
          end
        end
        ST_SPACE: begin
          if (w_rise) begin
            r_state <= ST_MARK;
            if (r_units >= CHAR_GAP_UNITS) begin
              r_code <= 6'd0;
              r_len  <= 3'd0;
            end
          end else if (w_wrap && (r_units == CHAR_GAP_UNITS - 3'd1)) begin
            r_sym_valid <= 1'b1;
            r_sym_code  <= r_code;
            r_sym_len   <= r_len;
            r_sym_seen  <= 1'b1;
          end else if (w_wrap && (r_units == WORD_GAP_UNITS - 3'd1)) begin
            r_state <= ST_IDLE;
            r_code  <= 6'd0;
            r_len   <= 3'd0;
            if (r_sym_seen) begin
              r_word_gap <= 1'b1;
              r_sym_seen <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SYM_VALID = r_sym_valid;
  assign SYM_CODE  = r_sym_code;
  assign SYM_LEN   = r_sym_len;
  assign WORD_GAP  = r_word_gap;
  assign ERR       = r_err;

endmodule
`default_nettype wire
